// File: rtl/seven_seg_show.sv
// seven_seg_show: 8-digit multiplexed 7-segment driver.
// Hex mode shows data nibbles directly.
// Decimal mode shows the result of a free-running sequential double-dabble converter.
module seven_seg_show #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        mod,
    input  logic [31:0] data,
    output logic [7:0]  SEG,
    output logic [7:0]  AN
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic {
        CONV_IDLE,
        CONV_SHIFT
    } conv_state_t;

    conv_state_t state, state_next;

    logic [CW-1:0] scan_cnt;
    logic [2:0]    digit_idx;
    logic [31:0]   bin_reg;
    logic [31:0]   bin_snap;
    logic [39:0]   bcd_reg;
    logic [39:0]   bcd_adj;
    logic [39:0]   bcd_shifted;
    logic [4:0]    shift_cnt;
    logic [31:0]   disp_bcd;
    logic          load;
    logic          last_shift;
    logic [3:0]    nibble;
    logic [7:0]    seg_code;

    // Active-low segment pattern {dp,g,f,e,d,c,b,a} for one hex digit
    function automatic logic [7:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_to_seg = 8'hC0;
            4'h1: hex_to_seg = 8'hF9;
            4'h2: hex_to_seg = 8'hA4;
            4'h3: hex_to_seg = 8'hB0;
            4'h4: hex_to_seg = 8'h99;
            4'h5: hex_to_seg = 8'h92;
            4'h6: hex_to_seg = 8'h82;
            4'h7: hex_to_seg = 8'hF8;
            4'h8: hex_to_seg = 8'h80;
            4'h9: hex_to_seg = 8'h90;
            4'hA: hex_to_seg = 8'h88;
            4'hB: hex_to_seg = 8'h83;
            4'hC: hex_to_seg = 8'hC6;
            4'hD: hex_to_seg = 8'hA1;
            4'hE: hex_to_seg = 8'h86;
            default: hex_to_seg = 8'h8E;
        endcase
    endfunction

    // Scan timer: each digit stays lit for SCAN_DIV cycles, then the index advances
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            scan_cnt  <= '0;
            digit_idx <= 3'd0;
        end else if (scan_cnt == CW'(SCAN_DIV - 1)) begin
            scan_cnt  <= '0;
            digit_idx <= digit_idx + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Add-3 correction on every BCD nibble that is 5 or more, ahead of the shift
    always_comb begin
        bcd_adj = bcd_reg;
        for (int i = 0; i < 10; i++) begin
            if (bcd_reg[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_reg[4*i +: 4] + 4'd3;
            end
        end
        bcd_shifted = {bcd_adj[38:0], bin_reg[31]};
    end

    // Converter control: reload on idle or whenever data moves under a running conversion
    always_comb begin
        state_next = state;
        load       = (state == CONV_IDLE) || (data != bin_snap);
        last_shift = (state == CONV_SHIFT) && !load && (shift_cnt == 5'd31);
        if (load) begin
            state_next = CONV_SHIFT;
        end else if (last_shift) begin
            state_next = CONV_IDLE;
        end
    end

    // Converter state register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= CONV_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Converter datapath: load operands, shift 32 times, publish lower 8 digits on the last shift
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            bin_reg   <= '0;
            bin_snap  <= '0;
            bcd_reg   <= '0;
            shift_cnt <= '0;
            disp_bcd  <= '0;
        end else if (load) begin
            bin_reg   <= data;
            bin_snap  <= data;
            bcd_reg   <= '0;
            shift_cnt <= '0;
        end else if (state == CONV_SHIFT) begin
            bin_reg   <= {bin_reg[30:0], 1'b0};
            bcd_reg   <= bcd_shifted;
            shift_cnt <= shift_cnt + 5'd1;
            if (last_shift) begin
                disp_bcd <= bcd_shifted[31:0];
            end
        end
    end

    // Pick the nibble for the active digit from live data or the decimal display register
    always_comb begin
        nibble = mod ? data[{digit_idx, 2'b00} +: 4] : disp_bcd[{digit_idx, 2'b00} +: 4];
        seg_code = hex_to_seg(nibble);
    end

    // Output registers: anode and segments change together every cycle
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            AN  <= 8'hFF;
            SEG <= 8'hFF;
        end else begin
            AN  <= ~(8'd1 << digit_idx);
            SEG <= seg_code;
        end
    end

endmodule

// File: tb/tb_seven_seg_show.sv
// tb_seven_seg_show: directed checks of scan order, hex and decimal display, and reset behaviour.
module tb_seven_seg_show;

    localparam int SCAN_DIV = 4;

    logic        clk;
    logic        clr;
    logic        mod;
    logic [31:0] data;
    logic [7:0]  SEG;
    logic [7:0]  AN;

    int compareCount;
    int mismatchCount;

    seven_seg_show #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk  (clk),
        .clr  (clr),
        .mod  (mod),
        .data (data),
        .SEG  (SEG),
        .AN   (AN)
    );

    // 100 MHz style free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count a comparison and report it when observed differs from expected
    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %02h, expected %02h", tag, observed, expected);
        end
    endtask

    // Drive new inputs on the falling edge so they are stable at the next rising edge
    task automatic applyStimulus(input logic newMod, input logic [31:0] newData);
        @(negedge clk);
        mod  = newMod;
        data = newData;
    endtask

    // Wait (bounded) for digit i to be lit, then check its segments
    task automatic checkDigit(input string tag, input int i, input logic [7:0] expSeg);
        logic [7:0] want;
        logic       found;
        want  = ~(8'd1 << i);
        found = 1'b0;
        for (int n = 0; n < 8 * SCAN_DIV + 4; n++) begin
            @(negedge clk);
            if (AN == want) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            checkOutput({tag, "_an_timeout"}, AN, want);
        end else begin
            checkOutput($sformatf("%s_d%0d", tag, i), SEG, expSeg);
        end
    endtask

    // Check all eight digits; expAll holds digit 7 in the top byte
    task automatic checkAllDigits(input string tag, input logic [63:0] expAll);
        for (int i = 0; i < 8; i++) begin
            checkDigit(tag, i, expAll[8*i +: 8]);
        end
    endtask

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        clr  = 1'b0;
        mod  = 1'b1;
        data = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_an", AN, 8'hFF);
        checkOutput("reset_seg", SEG, 8'hFF);

        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("first_an", AN, 8'hFE);
        checkOutput("first_seg", SEG, 8'hC0);
        for (int k = 1; k <= 8; k++) begin
            repeat (SCAN_DIV) @(posedge clk);
            #1;
            checkOutput($sformatf("scan_step%0d", k), AN, ~(8'd1 << (k % 8)));
        end

        applyStimulus(1'b1, 32'hDEADBEEF);
        checkAllDigits("hex_deadbeef", 64'hA1_86_88_A1_83_86_86_8E);

        applyStimulus(1'b0, 32'd12345678);
        repeat (34) @(posedge clk);
        checkAllDigits("dec_12345678", 64'hF9_A4_B0_99_92_82_F8_80);

        applyStimulus(1'b0, 32'hFFFFFFFF);
        repeat (34) @(posedge clk);
        checkAllDigits("dec_overflow", 64'h90_99_90_82_F8_A4_90_92);

        applyStimulus(1'b0, 32'h0);
        repeat (34) @(posedge clk);
        checkAllDigits("dec_zero", 64'hC0_C0_C0_C0_C0_C0_C0_C0);

        applyStimulus(1'b1, 32'h10);
        repeat (40) @(posedge clk);
        checkDigit("mode_hex", 0, 8'hC0);
        checkDigit("mode_hex", 1, 8'hF9);
        applyStimulus(1'b0, 32'h10);
        checkDigit("mode_dec", 0, 8'h82);
        checkDigit("mode_dec", 1, 8'hF9);
        checkDigit("mode_dec", 2, 8'hC0);

        applyStimulus(1'b0, 32'd12345678);
        repeat (16) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        #1;
        checkOutput("midconv_reset_an", AN, 8'hFF);
        checkOutput("midconv_reset_seg", SEG, 8'hFF);
        repeat (2) @(negedge clk);
        clr = 1'b1;
        repeat (34) @(posedge clk);
        checkAllDigits("post_reset_dec", 64'hF9_A4_B0_99_92_82_F8_80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
